// File: rtl/sdram_pkg.sv
// Types and helpers shared by the SDRAM port clients.
package sdram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_FLUSH
    } reader_state_t;

    function automatic int unsigned final_burst_words(input int unsigned remaining,
                                                      input int unsigned burst_len);
        return (remaining < burst_len) ? remaining : burst_len;
    endfunction

endpackage

// File: rtl/mem_port_if.sv
// One SDRAM controller port; DATA_WIDTH is the full burst width carried on q.
interface mem_port_if #(
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16
);
    localparam int BE_WIDTH = (DATA_WIDTH + 7) / 8;

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   byte_en;
    logic [DATA_WIDTH-1:0] q;
    logic                  wr;
    logic                  rd;
    logic                  available;
    logic                  ready;

    modport client (output addr, data, byte_en, wr, rd, input q, available, ready);
    modport server (input addr, data, byte_en, wr, rd, output q, available, ready);
endinterface

// File: rtl/mem_port_stream_reader_burst_fifo.sv
// Burst buffer between the memory port and the word unpacker.
module burst_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rd_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd) && !flush;
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, do_rd};
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/mem_port_stream_reader.sv
// Reads word_count words from an SDRAM port starting at start_addr and streams them out.
//   state | meaning
//   IDLE  | waiting for start
//   REQ   | issue next read once port available and buffer has room
//   WAIT  | one read outstanding, waiting for ready
//   DRAIN | all bursts received, emptying buffer before done
//   FLUSH | aborted with a read outstanding, swallowing its ready
module mem_port_stream_reader
    import sdram_pkg::*;
#(
    parameter int PORT_ADDR_WIDTH   = 25,
    parameter int DATA_WIDTH        = 16,
    parameter int PORT_BURST_LENGTH = 1,
    parameter int FIFO_DEPTH        = 4,
    parameter int COUNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [PORT_ADDR_WIDTH-1:0] start_addr,
    input  logic [COUNT_WIDTH-1:0]     word_count,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    mem_port_if.client                 mem
);
    localparam int BURST_W = PORT_BURST_LENGTH * DATA_WIDTH;
    localparam int IDX_W   = (PORT_BURST_LENGTH > 1) ? $clog2(PORT_BURST_LENGTH) : 1;

    reader_state_t              state_q, state_d;
    logic [PORT_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]     rem_q, rem_d;
    logic [COUNT_WIDTH-1:0]     out_rem_q, out_rem_d;
    logic [IDX_W-1:0]           idx_q, idx_d;

    logic               fifo_wr, fifo_rd, fifo_flush, fifo_full, fifo_empty;
    logic [BURST_W-1:0] fifo_rd_data, burst_shifted;
    logic               rd_req, xfer, last_word, abort_now;

    burst_fifo #(.WIDTH(BURST_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (mem.q),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem.addr    = addr_q;
    assign mem.rd      = rd_req;
    assign mem.wr      = 1'b0;
    assign mem.data    = '0;
    assign mem.byte_en = '1;

    // The unpacker reads straight from the FIFO head, so an empty FIFO means it is idle.
    assign out_valid     = !fifo_empty;
    assign burst_shifted = fifo_rd_data >> (DATA_WIDTH * int'(idx_q));
    assign out_data      = out_valid ? burst_shifted[DATA_WIDTH-1:0] : '0;
    assign busy          = (state_q != ST_IDLE) && !done;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        out_rem_d  = out_rem_q;
        idx_d      = idx_q;
        rd_req     = 1'b0;
        fifo_wr    = 1'b0;
        fifo_flush = 1'b0;
        done       = 1'b0;
        abort_now  = abort && (state_q != ST_IDLE);
        xfer       = out_valid && out_ready;
        last_word  = (idx_q == IDX_W'(PORT_BURST_LENGTH - 1)) || (out_rem_q == COUNT_WIDTH'(1));
        fifo_rd    = xfer && last_word;

        if (xfer) begin
            out_rem_d = out_rem_q - COUNT_WIDTH'(1);
            idx_d     = last_word ? '0 : idx_q + IDX_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d    = start_addr;
                    rem_d     = word_count;
                    out_rem_d = word_count;
                    idx_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rem_q == '0) begin
                    state_d = ST_DRAIN;
                end else if (mem.available && !fifo_full) begin
                    rd_req  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.ready) begin
                    fifo_wr = 1'b1;
                    addr_d  = addr_q + PORT_ADDR_WIDTH'(PORT_BURST_LENGTH);
                    rem_d   = rem_q - COUNT_WIDTH'(final_burst_words(32'(rem_q),
                                                                     32'(PORT_BURST_LENGTH)));
                    state_d = (rem_d == '0) ? ST_DRAIN : ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (mem.ready) begin
                    fifo_flush = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A ready landing in the abort cycle retires the read, so FLUSH is only needed otherwise.
        if (abort_now) begin
            rd_req     = 1'b0;
            fifo_wr    = 1'b0;
            done       = 1'b0;
            fifo_flush = 1'b1;
            rem_d      = '0;
            out_rem_d  = '0;
            idx_d      = '0;
            addr_d     = addr_q;
            state_d    = ((state_q == ST_WAIT || state_q == ST_FLUSH) && !mem.ready) ?
                         ST_FLUSH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            out_rem_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            out_rem_q <= out_rem_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_mem_port_stream_reader.sv
// Two readers (burst 1 and burst 4) against a behavioural SDRAM port, checked by a scoreboard.
module tb_mem_port_stream_reader;
    localparam int AW = 25;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]          start   = '0;
    logic [1:0]          abort_s = '0;
    logic [1:0]          oready  = '1;
    logic [1:0]          mavail  = '1;
    logic [1:0]          mready  = '0;
    logic [1:0][AW-1:0]  saddr   = '0;
    logic [1:0][15:0]    wcnt    = '0;
    logic [1:0][63:0]    mq      = '0;

    wire [1:0]           busy, done, ovalid, mrd, mwr;
    wire [1:0][15:0]     odata;
    wire [1:0][AW-1:0]   maddr;
    wire [1:0][63:0]     mdata;
    wire [1:0][7:0]      mbe;

    mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(16)) m1 ();
    mem_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) m4 ();

    assign m1.available = mavail[0];
    assign m1.ready     = mready[0];
    assign m1.q         = mq[0][15:0];
    assign m4.available = mavail[1];
    assign m4.ready     = mready[1];
    assign m4.q         = mq[1];
    assign mrd[0]   = m1.rd;
    assign mwr[0]   = m1.wr;
    assign maddr[0] = m1.addr;
    assign mdata[0] = {48'd0, m1.data};
    assign mbe[0]   = {6'd0, m1.byte_en};
    assign mrd[1]   = m4.rd;
    assign mwr[1]   = m4.wr;
    assign maddr[1] = m4.addr;
    assign mdata[1] = m4.data;
    assign mbe[1]   = m4.byte_en;

    mem_port_stream_reader #(
        .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(16), .PORT_BURST_LENGTH(1),
        .FIFO_DEPTH(4), .COUNT_WIDTH(16)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start[0]), .start_addr(saddr[0]),
        .word_count(wcnt[0]), .abort(abort_s[0]), .busy(busy[0]), .done(done[0]),
        .out_valid(ovalid[0]), .out_data(odata[0]), .out_ready(oready[0]), .mem(m1)
    );

    mem_port_stream_reader #(
        .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(16), .PORT_BURST_LENGTH(4),
        .FIFO_DEPTH(4), .COUNT_WIDTH(16)
    ) u_dut4 (
        .clk(clk), .reset(reset), .start(start[1]), .start_addr(saddr[1]),
        .word_count(wcnt[1]), .abort(abort_s[1]), .busy(busy[1]), .done(done[1]),
        .out_valid(ovalid[1]), .out_data(odata[1]), .out_ready(oready[1]), .mem(m4)
    );

    int nchecks = 0;
    int nerrors = 0;

    typedef logic [15:0]   wq_t[$];
    typedef logic [AW-1:0] aq_t[$];
    wq_t exp_w[2];
    aq_t exp_rd[2];
    int  exp_done[2] = '{0, 0};
    int  lat[2]      = '{1, 1};
    int  cd[2]       = '{0, 0};
    int  rd_cnt[2]   = '{0, 0};
    logic [AW-1:0]   pend_addr[2];
    logic [1:0]      chk_lat = 2'b11;
    logic [1:0]      toggle  = 2'b00;
    logic [1:0]      held_v  = 2'b00;
    logic [1:0][15:0] held_d = '0;

    function automatic int bl(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic [15:0] word_at(input logic [AW-1:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    function automatic logic [63:0] burst_data(input int i, input logic [AW-1:0] a);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < bl(i); j++) r[j*16 +: 16] = word_at(a + AW'(j));
        return r;
    endfunction

    function automatic string nm(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory port model: answers each rd with ready after lat cycles.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cd[i]     = 0;
                mready[i] = 1'b0;
            end else begin
                if (mready[i]) begin
                    if (chk_lat[i]) chk(nm("valid_after_ready", i), ovalid[i], 1);
                    else            chk(nm("discarded_ready_valid", i), ovalid[i], 0);
                end
                mready[i] = 1'b0;
                if (cd[i] > 0) begin
                    chk(nm("addr_hold", i), maddr[i], pend_addr[i]);
                    cd[i]--;
                    if (cd[i] == 0) begin
                        mready[i] = 1'b1;
                        mq[i]     = burst_data(i, pend_addr[i]);
                    end
                end
                if (mrd[i]) begin
                    rd_cnt[i]++;
                    chk(nm("single_outstanding", i), (cd[i] == 0) && !mready[i], 1);
                    chk(nm("rd_expected", i), exp_rd[i].size() != 0, 1);
                    if (exp_rd[i].size() != 0) chk(nm("rd_addr", i), maddr[i], exp_rd[i].pop_front());
                    pend_addr[i] = maddr[i];
                    cd[i]        = lat[i];
                end
            end
        end
    end

    // Output monitor: pops expected words, checks hold rules and done pulses.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                held_v[i] = 1'b0;
            end else begin
                if (held_v[i]) begin
                    chk(nm("hold_valid", i), ovalid[i], 1);
                    chk(nm("hold_data", i), odata[i], held_d[i]);
                end
                if (ovalid[i] && oready[i]) begin
                    chk(nm("out_expected", i), exp_w[i].size() != 0, 1);
                    if (exp_w[i].size() != 0) chk(nm("out_word", i), odata[i], exp_w[i].pop_front());
                end
                if (done[i]) begin
                    chk(nm("done_busy_low", i), busy[i], 0);
                    chk(nm("done_expected", i), exp_done[i] > 0, 1);
                    if (exp_done[i] > 0) exp_done[i]--;
                end
                held_v[i] = ovalid[i] && !oready[i] && !abort_s[i];
                held_d[i] = odata[i];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) if (toggle[i]) oready[i] = ~oready[i];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input int i, input logic [AW-1:0] a, input int n);
        for (int k = 0; k < n; k++) exp_w[i].push_back(word_at(a + AW'(k)));
        for (int k = 0; k < n; k += bl(i)) exp_rd[i].push_back(a + AW'(k));
        exp_done[i]++;
    endtask

    task automatic pulse_start(input int i, input logic [AW-1:0] a, input int n);
        start[i] = 1'b1;
        saddr[i] = a;
        wcnt[i]  = 16'(n);
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input string name);
        for (int c = 0; c < 2000; c++) begin
            if (exp_done[i] == 0 && exp_w[i].size() == 0 && exp_rd[i].size() == 0 && !busy[i]) break;
            tick();
        end
        chk(name, (exp_done[i] == 0) && (exp_w[i].size() == 0) && (exp_rd[i].size() == 0) && !busy[i], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;

        tick();
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk(nm("rst_busy", i), busy[i], 0);
            chk(nm("rst_done", i), done[i], 0);
            chk(nm("rst_valid", i), ovalid[i], 0);
            chk(nm("rst_data", i), odata[i], 0);
            chk(nm("rst_rd", i), mrd[i], 0);
            chk(nm("rst_addr", i), maddr[i], 0);
            chk(nm("mem_wr", i), mwr[i], 0);
            chk(nm("mem_data", i), mdata[i], 0);
            chk(nm("mem_byte_en", i), mbe[i], (i == 0) ? 64'h03 : 64'hFF);
        end
        tick();
        reset = 1'b0;
        tick();

        // burst 1, three words from 0x100
        expect_xfer(0, 25'h100, 3);
        pulse_start(0, 25'h100, 3);
        wait_idle(0, "burst1_count3");

        // burst 4, six words: second burst truncated
        expect_xfer(1, 25'h40, 6);
        pulse_start(1, 25'h40, 6);
        wait_idle(1, "burst4_count6");

        // zero count: done one cycle after busy rises
        expect_xfer(0, 25'h123, 0);
        pulse_start(0, 25'h123, 0);
        @(negedge clk);
        chk("count0_busy_rise", {busy[0], done[0]}, 2'b10);
        @(negedge clk);
        chk("count0_done", {busy[0], done[0]}, 2'b01);
        wait_idle(0, "count0_idle");

        // back-pressure: reads stop at FIFO depth; a start while busy is ignored
        oready[0] = 1'b0;
        snap = rd_cnt[0];
        expect_xfer(0, 25'h500, 32);
        pulse_start(0, 25'h500, 32);
        repeat (10) tick();
        pulse_start(0, 25'h777, 5);
        repeat (40) tick();
        chk("fifo_full_reads", rd_cnt[0] - snap, 4);
        chk("stalled_busy", busy[0], 1);
        oready[0] = 1'b1;
        wait_idle(0, "backpressure_count32");

        // address wrap at 2^25-1
        expect_xfer(0, 25'h1FF_FFFF, 2);
        pulse_start(0, 25'h1FF_FFFF, 2);
        wait_idle(0, "addr_wrap");

        // abort while a read is outstanding; its ready comes 5 cycles later
        lat[0]     = 6;
        chk_lat[0] = 1'b0;
        exp_rd[0].push_back(25'h200);
        pulse_start(0, 25'h200, 5);
        for (int c = 0; c < 20; c++) begin
            if (cd[0] > 0) break;
            tick();
        end
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        repeat (10) tick();
        chk("abort_wait_busy", busy[0], 0);
        chk("abort_wait_valid", ovalid[0], 0);
        chk("abort_wait_ready_seen", cd[0], 0);
        chk("abort_wait_rd_left", exp_rd[0].size(), 0);
        lat[0]     = 1;
        chk_lat[0] = 1'b1;
        expect_xfer(0, 25'h300, 2);
        pulse_start(0, 25'h300, 2);
        wait_idle(0, "after_abort_restart");

        // abort with no read outstanding while output is stalled
        oready[0] = 1'b0;
        snap = rd_cnt[0];
        for (int k = 0; k < 4; k++) exp_rd[0].push_back(25'h600 + AW'(k));
        pulse_start(0, 25'h600, 8);
        repeat (20) tick();
        chk("abort_req_valid_before", ovalid[0], 1);
        abort_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        chk("abort_req_valid", ovalid[0], 0);
        chk("abort_req_busy", busy[0], 0);
        chk("abort_req_reads", rd_cnt[0] - snap, 4);
        oready[0] = 1'b1;
        repeat (5) tick();

        // abort in IDLE does nothing
        abort_s[1] = 1'b1;
        tick();
        abort_s[1] = 1'b0;
        chk("abort_idle_busy", busy[1], 0);

        // burst 4 across the address wrap with alternating out_ready
        oready[1] = 1'b0;
        toggle[1] = 1'b1;
        expect_xfer(1, 25'h1FF_FFFE, 9);
        pulse_start(1, 25'h1FF_FFFE, 9);
        wait_idle(1, "burst4_wrap_toggle");
        toggle[1] = 1'b0;
        tick();
        oready[1] = 1'b1;

        repeat (5) tick();
        for (int i = 0; i < 2; i++) begin
            chk(nm("final_words_left", i), exp_w[i].size(), 0);
            chk(nm("final_done_left", i), exp_done[i], 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/mem_port_stream_reader.md
MEM_PORT_STREAM_READER -- requirements
Module: mem_port_stream_reader

Interface
REQ-001 The block SHALL have these parameters:
- PORT_ADDR_WIDTH, default 25, word address width.
- DATA_WIDTH, default 16, bits per word.
- PORT_BURST_LENGTH, default 1, words returned per read.
- FIFO_DEPTH, default 4, burst entries buffered; power of two, at least 2.
- COUNT_WIDTH, default 16, width of the word count.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle transfer request.
- start_addr  in  PORT_ADDR_WIDTH  first word address.
- word_count  in  COUNT_WIDTH  words to deliver.
- abort  in  1  cancel the transfer.
- busy  out  1  transfer in progress.
- done  out  1  single-cycle completion pulse.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH  output word.
- out_ready  in  1  sink accepts the word.
- mem  mem_port_if.client  -  the initiator end of one SDRAM controller port (signals addr, data, byte_en, q, wr, rd, available, ready).
REQ-003 The block SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-004 mem.wr SHALL be held at 0, mem.data at 0 and mem.byte_en at all ones.
REQ-005 The FSM SHALL have the states IDLE, REQ, WAIT, DRAIN and FLUSH.
REQ-006 In IDLE, start SHALL latch start_addr and word_count and go to REQ (busy=1 from the next cycle); start is ignored in any other state.
REQ-007 If the latched word_count is 0, the block SHALL go to DRAIN, issue no mem.rd, and pulse done on the following cycle.
REQ-008 In REQ, mem.rd SHALL pulse for exactly one cycle when mem.available=1, the FIFO is not full and no request is outstanding; the FSM then goes to WAIT.
REQ-009 mem.addr SHALL hold the current request address from the rd cycle until the matching mem.ready.
REQ-010 At most one read SHALL be outstanding at any time.
REQ-011 In WAIT, a cycle with mem.ready=1 SHALL write mem.q (PORT_BURST_LENGTH words) into the FIFO in that same cycle.
REQ-012 On that ready, the address SHALL advance by PORT_BURST_LENGTH and wrap modulo 2^PORT_ADDR_WIDTH.
REQ-013 On that ready, the remaining-word count SHALL decrease by min(PORT_BURST_LENGTH, remaining); the FSM then goes to REQ, or to DRAIN when the remaining count reaches 0.
REQ-014 The unpacker SHALL present burst words low word first (q[DATA_WIDTH-1:0] first).
REQ-015 In the final burst, words beyond the requested count SHALL be discarded and never presented.
REQ-016 out_valid/out_data SHALL follow valid/ready rules: once valid=1, data is held stable until out_ready=1; a word transfers when out_valid and out_ready are both 1.
REQ-017 A FIFO write and a FIFO read in the same cycle while the FIFO is full SHALL both succeed.
REQ-018 In DRAIN, once the FIFO is empty and the unpacker idle, done SHALL pulse for one cycle, with busy=0 in that same cycle, and the FSM returns to IDLE.
REQ-019 abort while busy SHALL take priority over start and all other events.
REQ-020 On abort with no read outstanding, the block SHALL flush the FIFO and unpacker, deassert out_valid next cycle, and return to IDLE without a done pulse.
REQ-021 On abort with a read outstanding, the block SHALL go to FLUSH and wait for mem.ready, discard that data, then flush as in REQ-020.
REQ-022 abort in IDLE SHALL have no effect.
REQ-023 Transfer latency: the first mem.rd SHALL occur no earlier than one cycle after start; the first out_valid SHALL occur one cycle after the first mem.ready.

Reset
REQ-024 Asserting reset SHALL immediately force the state to IDLE and set busy=0, done=0, out_valid=0, out_data=0, mem.rd=0, mem.addr=0, FIFO empty, counters 0.
REQ-025 After reset deasserts, any mem.ready belonging to a read issued before reset SHALL be ignored.

Structure
REQ-026 The FSM state enum and the function computing words-in-final-burst SHALL reside in the shared sdram package.
REQ-027 Burst buffering SHALL be a sub-module, burst_fifo, parameterised by width (PORT_BURST_LENGTH*DATA_WIDTH) and depth, with full, empty and a synchronous flush input.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Burst=1, start_addr=0x100, count=3, out_ready=1 -> three rd at 0x100, 0x101, 0x102; words emitted in order; one done pulse.
- Burst=4, count=6 -> two reads at A and A+4; exactly 6 words out, the last 2 of the second burst dropped.
- count=0 -> no mem.rd, done one cycle after busy rises.
- out_ready=0 for 50 cycles, count=32, FIFO_DEPTH=4 -> rd stops once the FIFO is full; no word lost or duplicated after release.
- abort asserted while WAIT, with ready arriving 5 cycles later -> that data discarded, out_valid=0, IDLE, no done; a following start behaves as after reset.
- start_addr=2^25-1, burst=1, count=2 -> second read at address 0.
